vx_mask_drain: RTL and testbench
================================

// Module: vx_mask_drain
// PURPOSE
// - Serialises an N-bit request/thread mask into a stream of set-bit indices, one per cycle.
// - Sits directly downstream of the priority encoder: the held mask feeds VX_lzc; its index is registered state here.
// - Used wherever a mask must be walked lane by lane (per-thread replay, scatter issue, per-bank dispatch).
// - Carries a sideband tag with every index; flags the final index of each mask.
// PARAMETERS
// - N        8        mask width; N >= 1
// - REVERSE  0        0: highest set bit first (leading-zero order); 1: lowest set bit first
// - TAGW     4        sideband tag width; TAGW >= 1
// - LOGN     LOG2UP(N) index width (derived, not overridden)
// PORTS
// - clk        in   1     clock
// - reset      in   1     synchronous, active-high reset
// - in_valid   in   1     input mask offered
// - in_mask    in   N     mask to drain
// - in_tag     in   TAGW  tag attached to every index of this mask
// - in_ready   out  1     block can accept a new mask
// - out_valid  out  1     out_index/out_tag/out_last valid
// - out_index  out  LOGN  bit position (0 = LSB) of the selected set bit
// - out_tag    out  TAGW  tag of the mask being drained
// - out_last   out  1     this is the last set bit of the mask
// - out_ready  in   1     consumer accepts current index
// BEHAVIOUR
// - State: rem_mask[N], tag_r[TAGW]. Reset: rem_mask=0, tag_r=0 -> out_valid=0, in_ready=1, out_last=0.
// - FSM implied by rem_mask: IDLE (rem_mask==0) / DRAIN (rem_mask!=0). No other state.
// - in_ready = (rem_mask == 0); registered-only, no combinational path from out_ready.
// - Accept (in_valid & in_ready): rem_mask <= in_mask, tag_r <= in_tag. First index visible next cycle (latency 1).
// - Zero mask accepted: consumed, produces no output, in_ready stays 1.
// - out_valid = |rem_mask. out_index = bit position chosen by VX_lzc on rem_mask:
//   REVERSE=0 -> position of MSB set = N-1-lzc; REVERSE=1 -> trailing-zero count.
// - out_last = out_valid & (rem_mask has exactly one bit set); computed as rem_mask & (rem_mask-1) == 0.
// - Output handshake (out_valid & out_ready): clear selected bit in rem_mask. Throughput 1 index/cycle.
// - out_valid & !out_ready: rem_mask, out_index, out_tag, out_last held stable (AXI-style, no retraction).
// - After last handshake rem_mask==0 -> in_ready=1 next cycle; minimum gap between masks = 1 idle cycle.
// - Acceptance and output handshake never coincide (in_ready implies out_valid=0).
// - N==1: out_index=0, out_last=out_valid.
// - Reset mid-drain: rem_mask cleared next edge, remaining indices discarded, out_valid=0 following cycle.
// - Assertions: out_index stable while out_valid & !out_ready; selected bit always set in rem_mask.
// STRUCTURE
// - No shared-package typedefs needed; LOGN derived locally; state is the mask itself (no enum).
// - One sub-module: VX_lzc (N, REVERSE) instantiated on rem_mask; its valid output must equal out_valid.
// - Bit-clear uses a one-hot decode of out_index; keep outside the sub-module.
// TESTING
// - N=8,REVERSE=0, mask 8'b1010_0010 tag 3, out_ready=1 -> index 7,5,1 on consecutive cycles, tag 3, last only on 1.
// - Same mask, REVERSE=1 -> index 1,5,7, last on 7; in_ready=0 for those 3 cycles, 1 on the 4th.
// - Backpressure: out_ready=0 for 4 cycles while index 5 presented -> index/tag/last unchanged, no bit cleared.
// - Zero mask then 8'b0000_0001 -> zero mask yields no out_valid; next mask yields single index 0 with out_last=1.
// - Full mask 8'hFF, random out_ready -> exactly 8 indices 7..0 in order, one out_last, no duplicates/drops.
// - Reset asserted after 2 of 3 indices -> out_valid=0 and in_ready=1 the cycle after reset; no stale index later.

Source files
------------

// File: rtl/vx_mask_drain_pkg.sv
// ---------------------------------------------------------------------------
// vx_mask_drain_pkg
//
// Shared helpers for the mask-drain slice.
//
// The drain block does not need any shared typedefs because its only state is
// the remaining mask itself. This package holds the index-width helper and the
// default widths, so the top and the zero-count sub-module size their index
// ports the same way.
// ---------------------------------------------------------------------------
package vx_mask_drain_pkg;

    // Defaults used by the top-level parameter list.
    localparam int DEFAULT_N    = 8;
    localparam int DEFAULT_TAGW = 4;

    // Index width for an N-entry vector.
    // A one-entry vector still gets a one-bit index so that no port collapses
    // to zero width.
    function automatic int log2up(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/vx_mask_drain_lzc.sv
// ---------------------------------------------------------------------------
// vx_mask_drain_lzc
//
// Counts the zeros in front of the first set bit of data_in.
//
// The scan direction depends on REVERSE:
//   REVERSE = 0 : leading-zero count, scanning from the MSB towards the LSB.
//   REVERSE = 1 : trailing-zero count, scanning from the LSB towards the MSB.
//
// Ports
//   data_in   in   N     vector to scan
//   cnt_out   out  LOGN  number of zeros before the first set bit
//   valid_out out  1     data_in has at least one set bit
//
// When valid_out is 0, cnt_out is 0 and carries no meaning.
// ---------------------------------------------------------------------------
module vx_mask_drain_lzc
    import vx_mask_drain_pkg::*;
#(
    parameter  int N       = 8,
    parameter  int REVERSE = 0,
    localparam int LOGN    = log2up(N)
) (
    input  logic [N-1:0]    data_in,
    output logic [LOGN-1:0] cnt_out,
    output logic            valid_out
);

    // Priority scan.
    // The found flag freezes the count at the first set bit met in the chosen
    // direction. The zeros already passed are exactly the loop index at that
    // point.
    always_comb begin
        logic found;
        found   = 1'b0;
        cnt_out = '0;
        for (int i = 0; i < N; i++) begin
            if (REVERSE == 0) begin
                if (!found && data_in[N-1-i]) begin
                    cnt_out = LOGN'(i);
                    found   = 1'b1;
                end
            end else begin
                if (!found && data_in[i]) begin
                    cnt_out = LOGN'(i);
                    found   = 1'b1;
                end
            end
        end
    end

    assign valid_out = |data_in;

endmodule

// File: rtl/vx_mask_drain.sv
// ---------------------------------------------------------------------------
// vx_mask_drain
//
// Walks an N-bit mask and presents the positions of its set bits one per
// cycle. Each position comes with the tag that arrived with the mask, and the
// final position of every mask is flagged.
//
// Parameters
//   N       mask width (N >= 1)
//   REVERSE 0: highest set bit first, 1: lowest set bit first
//   TAGW    sideband tag width (TAGW >= 1)
//   LOGN    index width, derived from N
//
// Ports
//   clk        in   1     clock
//   reset      in   1     synchronous, active-high reset
//   in_valid   in   1     a new mask is offered
//   in_mask    in   N     mask to drain
//   in_tag     in   TAGW  tag attached to every index of this mask
//   in_ready   out  1     block is idle and takes a mask this cycle
//   out_valid  out  1     out_index / out_tag / out_last are valid
//   out_index  out  LOGN  bit position of the selected set bit (0 = LSB)
//   out_tag    out  TAGW  tag of the mask being drained
//   out_last   out  1     selected bit is the last one left in the mask
//   out_ready  in   1     consumer takes the current index
//
// The only state is the remaining mask plus its tag. An all-zero remaining
// mask means idle, anything else means draining. Because of that, in_ready and
// out_valid are mutually exclusive, and in_ready never depends on out_ready.
// ---------------------------------------------------------------------------
module vx_mask_drain
    import vx_mask_drain_pkg::*;
#(
    parameter  int N       = DEFAULT_N,
    parameter  int REVERSE = 0,
    parameter  int TAGW    = DEFAULT_TAGW,
    localparam int LOGN    = log2up(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [N-1:0]    in_mask,
    input  logic [TAGW-1:0] in_tag,
    output logic            in_ready,
    output logic            out_valid,
    output logic [LOGN-1:0] out_index,
    output logic [TAGW-1:0] out_tag,
    output logic            out_last,
    input  logic            out_ready
);

    localparam logic [LOGN-1:0] TOP_INDEX = LOGN'(N - 1);

    logic [N-1:0]    rem_mask;
    logic [N-1:0]    rem_mask_next;
    logic [TAGW-1:0] tag_r;
    logic [TAGW-1:0] tag_next;

    logic [LOGN-1:0] zero_cnt;
    logic            lzc_valid;
    logic [N-1:0]    sel_onehot;
    logic [N-1:0]    rem_minus_one;
    logic            accept;
    logic            out_fire;

    // The counter only reports how many zeros sit in front of the first set
    // bit. In MSB-first order that count is measured down from the top bit,
    // so it has to be turned back into a bit position here.
    vx_mask_drain_lzc #(
        .N       (N),
        .REVERSE (REVERSE)
    ) u_lzc (
        .data_in   (rem_mask),
        .cnt_out   (zero_cnt),
        .valid_out (lzc_valid)
    );

    assign out_index = (REVERSE != 0) ? zero_cnt : (TOP_INDEX - zero_cnt);
    assign out_tag   = tag_r;
    assign out_valid = |rem_mask;
    assign in_ready  = (rem_mask == '0);

    // A mask with exactly one set bit has its lowest set bit cleared by
    // x & (x-1), which leaves zero. That identifies the last index without
    // running a population count.
    assign rem_minus_one = rem_mask - N'(1);
    assign out_last      = out_valid && ((rem_mask & rem_minus_one) == '0);

    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // One-hot decode of the presented index.
    // A handshake uses it to knock the index out of the remaining mask.
    always_comb begin
        sel_onehot = '0;
        for (int i = 0; i < N; i++) begin
            sel_onehot[i] = (out_index == LOGN'(i));
        end
    end

    // Next-state logic.
    // A new mask can only arrive while idle, and an index can only leave
    // while draining, so the two branches never compete. Accepting a zero
    // mask still captures the tag, but the block stays idle.
    always_comb begin
        rem_mask_next = rem_mask;
        tag_next      = tag_r;
        if (accept) begin
            rem_mask_next = in_mask;
            tag_next      = in_tag;
        end else if (out_fire) begin
            rem_mask_next = rem_mask & ~sel_onehot;
        end
    end

    // State register.
    // Reset wipes any mask part-way through draining, so indices that had
    // not yet been handed out are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_mask <= '0;
            tag_r    <= '0;
        end else begin
            rem_mask <= rem_mask_next;
            tag_r    <= tag_next;
        end
    end

`ifndef SYNTHESIS
    // Stalled outputs must hold still until the consumer takes them.
    a_index_stable : assert property (@(posedge clk) disable iff (reset)
        (out_valid && !out_ready) |=> (out_valid && out_index == $past(out_index)));

    a_tag_stable : assert property (@(posedge clk) disable iff (reset)
        (out_valid && !out_ready) |=> (out_tag == $past(out_tag) && out_last == $past(out_last)));

    // Whatever index is presented must name a bit that is still pending.
    a_sel_is_set : assert property (@(posedge clk) disable iff (reset)
        out_valid |-> ((rem_mask & sel_onehot) != '0));

    // The counter's own notion of "any bit set" has to match out_valid.
    a_lzc_valid : assert property (@(posedge clk) disable iff (reset)
        lzc_valid == out_valid);

    a_no_overlap : assert property (@(posedge clk) disable iff (reset)
        !(in_ready && out_valid));
`endif

endmodule

// File: tb/tb_vx_mask_drain.sv
// ---------------------------------------------------------------------------
// tb_vx_mask_drain
//
// Self-checking bench with three instances:
//   dut0 : N=8, REVERSE=0, driven from a vector table plus hand-written
//          sequences
//   dut1 : N=8, REVERSE=1
//   dut2 : N=1
//
// Inputs are driven and outputs are sampled on the falling clock edge, away
// from the rising edge where the design updates.
// ---------------------------------------------------------------------------
module tb_vx_mask_drain;

    logic       clk;
    logic       reset;

    logic       in_valid;
    logic [7:0] in_mask;
    logic [3:0] in_tag;
    logic       in_ready;
    logic       out_valid;
    logic [2:0] out_index;
    logic [3:0] out_tag;
    logic       out_last;
    logic       out_ready;

    logic       r_in_valid;
    logic [7:0] r_in_mask;
    logic [3:0] r_in_tag;
    logic       r_in_ready;
    logic       r_out_valid;
    logic [2:0] r_out_index;
    logic [3:0] r_out_tag;
    logic       r_out_last;
    logic       r_out_ready;

    logic       s_in_valid;
    logic [0:0] s_in_mask;
    logic [3:0] s_in_tag;
    logic       s_in_ready;
    logic       s_out_valid;
    logic [0:0] s_out_index;
    logic [3:0] s_out_tag;
    logic       s_out_last;
    logic       s_out_ready;

    int num_compared = 0;
    int num_mismatched = 0;

    vx_mask_drain #(.N(8), .REVERSE(0), .TAGW(4)) dut0 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_mask   (in_mask),
        .in_tag    (in_tag),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_index (out_index),
        .out_tag   (out_tag),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    vx_mask_drain #(.N(8), .REVERSE(1), .TAGW(4)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (r_in_valid),
        .in_mask   (r_in_mask),
        .in_tag    (r_in_tag),
        .in_ready  (r_in_ready),
        .out_valid (r_out_valid),
        .out_index (r_out_index),
        .out_tag   (r_out_tag),
        .out_last  (r_out_last),
        .out_ready (r_out_ready)
    );

    vx_mask_drain #(.N(1), .REVERSE(0), .TAGW(4)) dut2 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (s_in_valid),
        .in_mask   (s_in_mask),
        .in_tag    (s_in_tag),
        .in_ready  (s_in_ready),
        .out_valid (s_out_valid),
        .out_index (s_out_index),
        .out_tag   (s_out_tag),
        .out_last  (s_out_last),
        .out_ready (s_out_ready)
    );

    always #5 clk = ~clk;

    // One table row = inputs driven this cycle + outputs expected this cycle
    // (the outputs reflect state from before this cycle's rising edge).
    typedef struct packed {
        logic       iv;
        logic [7:0] mask;
        logic [3:0] tag;
        logic       ordy;
        logic       exp_ov;
        logic [2:0] exp_idx;
        logic [3:0] exp_tag;
        logic       exp_last;
        logic       exp_ir;
    } vec_t;

    vec_t vecs [16];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        num_compared++;
        if (actual !== expected) begin
            num_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [7:0] mask,
                                 input logic [3:0] tag, input logic ordy);
        in_valid  = iv;
        in_mask   = mask;
        in_tag    = tag;
        out_ready = ordy;
    endtask

    initial begin
        int exp_next;
        int seen;
        int lasts;
        int cyc;

        clk = 1'b0;
        reset = 1'b1;
        applyStimulus(1'b0, 8'h00, 4'd0, 1'b0);
        r_in_valid = 1'b0; r_in_mask = 8'h00; r_in_tag = 4'd0; r_out_ready = 1'b0;
        s_in_valid = 1'b0; s_in_mask = 1'b0;  s_in_tag = 4'd0; s_out_ready = 1'b0;

        //                 iv    mask   tag   ordy  ov    idx   tag   last  ir
        vecs[0]  = '{1'b1, 8'hA2, 4'd3, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 8'h00, 4'd0, 1'b1, 1'b1, 3'd7, 4'd3, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, 4'd0, 1'b1, 1'b1, 3'd5, 4'd3, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, 4'd0, 1'b1, 1'b1, 3'd1, 4'd3, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 8'hA2, 4'd5, 1'b0, 1'b0, 3'd0, 4'd3, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 8'h00, 4'd0, 1'b1, 1'b1, 3'd7, 4'd5, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 3'd5, 4'd5, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 3'd5, 4'd5, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 3'd5, 4'd5, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 3'd5, 4'd5, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 8'h00, 4'd0, 1'b1, 1'b1, 3'd5, 4'd5, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 8'h00, 4'd0, 1'b1, 1'b1, 3'd1, 4'd5, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 8'h00, 4'd9, 1'b1, 1'b0, 3'd0, 4'd5, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 8'h01, 4'd2, 1'b1, 1'b0, 3'd0, 4'd9, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 8'hFF, 4'd7, 1'b1, 1'b1, 3'd0, 4'd2, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 3'd0, 4'd2, 1'b0, 1'b1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state of the other two instances.
        checkOutput("rev reset out_valid", 32'(r_out_valid), 32'd0);
        checkOutput("rev reset in_ready",  32'(r_in_ready),  32'd1);
        checkOutput("n1 reset out_valid",  32'(s_out_valid), 32'd0);
        checkOutput("n1 reset out_last",   32'(s_out_last),  32'd0);

        // Table: MSB-first drain, backpressure, zero mask, single bit,
        // input ignored while draining.
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
            checkOutput($sformatf("row%0d in_ready", i),  32'(in_ready),  32'(vecs[i].exp_ir));
            checkOutput($sformatf("row%0d out_tag", i),   32'(out_tag),   32'(vecs[i].exp_tag));
            checkOutput($sformatf("row%0d out_last", i),  32'(out_last),  32'(vecs[i].exp_last));
            if (vecs[i].exp_ov)
                checkOutput($sformatf("row%0d out_index", i), 32'(out_index), 32'(vecs[i].exp_idx));
            applyStimulus(vecs[i].iv, vecs[i].mask, vecs[i].tag, vecs[i].ordy);
            @(negedge clk);
        end

        // Full mask under random backpressure: indices 7..0, in order, once.
        applyStimulus(1'b1, 8'hFF, 4'd4, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 8'h00, 4'd0, 1'b0);
        exp_next = 7;
        seen = 0;
        lasts = 0;
        cyc = 0;
        while (seen < 8 && cyc < 200) begin
            out_ready = 1'($urandom_range(1, 0));
            checkOutput("full out_valid", 32'(out_valid), 32'd1);
            if (out_valid) begin
                checkOutput("full out_index", 32'(out_index), 32'(exp_next));
                checkOutput("full out_tag", 32'(out_tag), 32'd4);
                checkOutput("full out_last", 32'(out_last), (exp_next == 0) ? 32'd1 : 32'd0);
                if (out_ready) begin
                    seen++;
                    exp_next--;
                    if (out_last) lasts++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        checkOutput("full index count", 32'(seen), 32'd8);
        checkOutput("full last count", 32'(lasts), 32'd1);
        checkOutput("full done out_valid", 32'(out_valid), 32'd0);
        checkOutput("full done in_ready", 32'(in_ready), 32'd1);

        // REVERSE=1: 0xA2 drains as 1, 5, 7; ready again on the 4th cycle.
        r_in_valid = 1'b1; r_in_mask = 8'hA2; r_in_tag = 4'd3; r_out_ready = 1'b1;
        @(negedge clk);
        r_in_valid = 1'b0;
        checkOutput("rev c1 index", 32'(r_out_index), 32'd1);
        checkOutput("rev c1 last",  32'(r_out_last),  32'd0);
        checkOutput("rev c1 ready", 32'(r_in_ready),  32'd0);
        checkOutput("rev c1 tag",   32'(r_out_tag),   32'd3);
        @(negedge clk);
        checkOutput("rev c2 index", 32'(r_out_index), 32'd5);
        checkOutput("rev c2 last",  32'(r_out_last),  32'd0);
        checkOutput("rev c2 ready", 32'(r_in_ready),  32'd0);
        @(negedge clk);
        checkOutput("rev c3 index", 32'(r_out_index), 32'd7);
        checkOutput("rev c3 last",  32'(r_out_last),  32'd1);
        checkOutput("rev c3 ready", 32'(r_in_ready),  32'd0);
        @(negedge clk);
        checkOutput("rev c4 out_valid", 32'(r_out_valid), 32'd0);
        checkOutput("rev c4 ready",     32'(r_in_ready),  32'd1);

        // N=1: single index 0 that is always last; held while stalled.
        s_in_valid = 1'b1; s_in_mask = 1'b1; s_in_tag = 4'd1; s_out_ready = 1'b0;
        @(negedge clk);
        s_in_valid = 1'b0;
        checkOutput("n1 out_valid", 32'(s_out_valid), 32'd1);
        checkOutput("n1 out_index", 32'(s_out_index), 32'd0);
        checkOutput("n1 out_last",  32'(s_out_last),  32'd1);
        @(negedge clk);
        checkOutput("n1 stall out_valid", 32'(s_out_valid), 32'd1);
        checkOutput("n1 stall tag",       32'(s_out_tag),   32'd1);
        s_out_ready = 1'b1;
        @(negedge clk);
        checkOutput("n1 done out_valid", 32'(s_out_valid), 32'd0);
        checkOutput("n1 done in_ready",  32'(s_in_ready),  32'd1);

        // Reset after two of three indices: the third must never appear.
        applyStimulus(1'b1, 8'hA2, 4'd6, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 8'h00, 4'd0, 1'b1);
        checkOutput("rst idx a", 32'(out_index), 32'd7);
        @(negedge clk);
        checkOutput("rst idx b", 32'(out_index), 32'd5);
        @(negedge clk);
        checkOutput("rst pending valid", 32'(out_valid), 32'd1);
        checkOutput("rst pending idx", 32'(out_index), 32'd1);
        out_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("rst after out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst after in_ready",  32'(in_ready),  32'd1);
        checkOutput("rst after tag",       32'(out_tag),   32'd0);
        checkOutput("rst after last",      32'(out_last),  32'd0);
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("rst no stale valid", 32'(out_valid), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
